mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single four-bank main memory between the instruction-cache controller (requester 0) and the data-cache controller (requester 1).
- Arbitrates word requests and honours the memory's stall.
- Lets a cache controller lock ownership for a multi-word line fill or writeback.
- Routes read data back to the requester that issued it, after the fixed memory read latency.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data word width.
- RD_LAT, 2, cycles from an accepted read to mem_data_out being valid (range 1..4).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- req_rd_0 / req_rd_1  in  1  read request, held until acked
- req_wr_0 / req_wr_1  in  1  write request, held until acked
- req_lock_0 / req_lock_1  in  1  keep ownership after the current word (burst)
- req_addr_0 / req_addr_1  in  ADDR_W  word address
- req_data_0 / req_data_1  in  DATA_W  write data
- req_ack_0 / req_ack_1  out  1  request accepted by memory this cycle
- rsp_valid_0 / rsp_valid_1  out  1  read data valid this cycle
- rsp_data_0 / rsp_data_1  out  DATA_W  read data; 0 when rsp_valid is low
- mem_addr  out  ADDR_W  address to memory
- mem_data_in  out  DATA_W  write data to memory
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_stall  in  1  memory cannot accept a request this cycle
- mem_data_out  in  DATA_W  memory read data
- err  out  1  protocol error, registered

Behaviour:
- Interface (already decided): one clock, clk. Reset is rst, synchronous and active-high.
- Ownership FSM states:
  - FREE: no owner.
  - OWN0: requester 0 owns the memory.
  - OWN1: requester 1 owns the memory.
- FREE:
  - Candidate = round-robin winner among requesters with rd|wr asserted.
  - rr_last register records the last requester granted. The other requester wins a tie.
  - rr_last reset value: 1, so requester 0 wins the first tie.
- OWNx: candidate is x only. The other requester waits even if x has no request this cycle.
- Drive: mem_rd/mem_wr/mem_addr/mem_data_in are driven combinationally from the candidate. With no candidate, strobes are 0 and addr/data are 0.
- Acceptance: req_ack_x = candidate==x & ~mem_stall & ~rst. The request is consumed on that edge.
- Transitions on an accepted word:
  - If req_lock_x is high: go to OWNx.
  - If req_lock_x is low: go to FREE and set rr_last=x.
- In OWNx with no request from x and req_lock_x low: go to FREE next cycle. No word is issued that cycle.
- Stall: when mem_stall is high, strobes stay driven and no ack is given. The FSM, rr_last and requester inputs are held.
- Read return:
  - An RD_LAT-deep shift register carries {valid, id}, inserted on each accepted read.
  - At the tail, rsp_valid_id=1 and rsp_data_id=mem_data_out.
  - Back-to-back reads return back-to-back, in order.
  - Writes insert an invalid entry.
- Latency: read ack at cycle T gives rsp_valid at T+RD_LAT. Write completes at ack; there is no response.
- err:
  - Set for one cycle after an accepted request with rd and wr both high. That request is issued as a read.
  - Also set for one cycle if req_lock_x is high while x has no rd/wr in FREE. That lock is ignored.
- Reset:
  - All outputs 0, FSM=FREE, rr_last=1, shift pipeline cleared.
  - Reads in flight at reset are dropped: no rsp_valid is ever produced for them.
  - mem_rd/mem_wr are forced 0 during rst.

Optional Feature:
- Macro: MEM_ARB_DPRIO_EN.
- Defined: in FREE, requester 1 (D-cache) always wins when both request. rr_last is unused, and its register is removed.
- Undefined: round-robin as above.
- Ownership lock behaviour is identical either way.

Decomposition:
- Shared package / include file mem_arb_defs holds:
  - state encodings FREE=2'b00, OWN0=2'b01, OWN1=2'b10;
  - requester id constants REQ_I=0, REQ_D=1;
  - the default RD_LAT.
- One natural sub-module: mem_arb_rsp_pipe, the RD_LAT-deep {valid,id} shift register with demux to the rsp ports.
- The FSM, round-robin logic and muxing stay in mem_arbiter.

Test Plan:
- Single read: req_rd_1, addr 0x0040, mem returns 0xBEEF; RD_LAT=2, no stall.
  -> req_ack_1 at T; rsp_valid_1 with 0xBEEF at T+2; rsp_valid_0 stays 0.
- Contention after reset: both read every cycle, no lock.
  -> acks alternate 0,1,0,1.
  -> With MEM_ARB_DPRIO_EN: requester 1 acked every cycle, requester 0 never acked.
- Locked fill: requester 1 locks for 4 reads at 0x0100–0x0106 while requester 0 requests continuously.
  -> Four consecutive req_ack_1, no req_ack_0 until the cycle after lock drops.
  -> Responses return in order.
- Stall: mem_stall high for 3 cycles during a requester 0 write to 0x0020 with data 0x1234.
  -> mem_wr/addr/data held for 3 cycles, ack only on the 4th.
- Reset mid-flight: rst asserted one cycle after a read ack.
  -> No rsp_valid is produced; all outputs 0; FSM=FREE.
- Protocol error: requester 0 asserts rd and wr together.
  -> Issued as a read; err=1 for exactly one cycle after the ack.

Source files
------------

// File: rtl/mem_arb_defs.sv
// mem_arb_defs: shared encodings for the memory arbiter slice.
// Ownership states, requester ids, default read latency and the read-return tag.
// Imported by mem_arbiter and mem_arb_rsp_pipe.
package mem_arb_defs;

  typedef enum logic [1:0] {
    FREE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_t;

  localparam logic REQ_I = 1'b0;  // instruction-cache controller
  localparam logic REQ_D = 1'b1;  // data-cache controller

  localparam int RD_LAT_DEF = 2;

  // One slot of the read-return pipeline: was a read issued, and by whom
  typedef struct packed {
    logic vld;
    logic id;
  } rsp_tag_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one cache controller's word-request channel into the arbiter.
// master = cache controller side, slave = arbiter side.
// Request fields are held by the master until ack; read data returns on rsp_valid/rsp_data.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              rd;
  logic              wr;
  logic              lock;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              ack;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  modport master (output rd, wr, lock, addr, data, input ack, rsp_valid, rsp_data);
  modport slave  (input rd, wr, lock, addr, data, output ack, rsp_valid, rsp_data);
endinterface

// File: rtl/mem_arb_rsp_pipe.sv
// mem_arb_rsp_pipe: RD_LAT-deep {valid,id} shift register tracking issued reads (RD_LAT 1..4).
// A tag inserted at cycle T reaches the tail at T+RD_LAT, when memory read data is valid.
// No backpressure: the memory latency is fixed, so the pipe shifts every cycle.
module mem_arb_rsp_pipe
  import mem_arb_defs::*;
#(
  parameter int DATA_W = 16,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  rsp_tag_t          tag_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              rsp_valid_0,
  output logic              rsp_valid_1,
  output logic [DATA_W-1:0] rsp_data_0,
  output logic [DATA_W-1:0] rsp_data_1
);

  rsp_tag_t pipe [RD_LAT];
  rsp_tag_t tail;

  // Shift tags toward the tail; reset drops every read in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tail = pipe[RD_LAT-1];

  // Steer the returning word to its issuer; idle data lines read as zero
  always_comb begin
    rsp_valid_0 = tail.vld & (tail.id == REQ_I) & ~rst;
    rsp_valid_1 = tail.vld & (tail.id == REQ_D) & ~rst;
    rsp_data_0  = rsp_valid_0 ? mem_data_out : '0;
    rsp_data_1  = rsp_valid_1 ? mem_data_out : '0;
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the four-bank main memory between I-cache (req0) and D-cache (req1), with lockable bursts.
// Latency: ack is combinational in the issuing cycle; read data returns RD_LAT cycles after the ack.
// Backpressure: mem_stall holds strobes, FSM and round-robin state. Macro MEM_ARB_DPRIO_EN: D-cache wins ties in FREE.
module mem_arbiter
  import mem_arb_defs::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      req0,
  mem_arbiter_if.slave      req1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic              mem_stall,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              err
);

  arb_state_t        state, state_nxt;
  logic              any0, any1, tie_win;
  logic              cand_vld, cand_id, cand_rd, cand_wr, cand_lock;
  logic [ADDR_W-1:0] cand_addr;
  logic [DATA_W-1:0] cand_data;
  logic              accept, err_nxt;
  rsp_tag_t          tag_in;

  assign any0 = req0.rd | req0.wr;
  assign any1 = req1.rd | req1.wr;

`ifdef MEM_ARB_DPRIO_EN
  assign tie_win = REQ_D;
`else
  logic rr_last;

  // Remember who got the last unlocked word so the other side wins the next tie
  always_ff @(posedge clk) begin
    if (rst)                     rr_last <= REQ_D;
    else if (accept && !cand_lock) rr_last <= cand_id;
  end

  assign tie_win = (rr_last == REQ_I) ? REQ_D : REQ_I;
`endif

  // Choose the candidate: arbitrate when free, only the owner while locked
  always_comb begin
    cand_vld = 1'b0;
    cand_id  = REQ_I;
    case (state)
      FREE: begin
        if (any0 && any1) begin
          cand_vld = 1'b1;
          cand_id  = tie_win;
        end else if (any0) begin
          cand_vld = 1'b1;
          cand_id  = REQ_I;
        end else if (any1) begin
          cand_vld = 1'b1;
          cand_id  = REQ_D;
        end
      end
      OWN0: cand_vld = any0;
      OWN1: begin
        cand_vld = any1;
        cand_id  = REQ_D;
      end
      default: ;
    endcase
  end

  // Mux the candidate's request fields; zero when nobody is selected
  always_comb begin
    cand_rd   = 1'b0;
    cand_wr   = 1'b0;
    cand_lock = 1'b0;
    cand_addr = '0;
    cand_data = '0;
    if (cand_vld) begin
      if (cand_id == REQ_D) begin
        cand_rd   = req1.rd;
        cand_wr   = req1.wr;
        cand_lock = req1.lock;
        cand_addr = req1.addr;
        cand_data = req1.data;
      end else begin
        cand_rd   = req0.rd;
        cand_wr   = req0.wr;
        cand_lock = req0.lock;
        cand_addr = req0.addr;
        cand_data = req0.data;
      end
    end
  end

  assign accept = cand_vld & ~mem_stall & ~rst;

  // Ownership state register
  always_ff @(posedge clk) begin
    if (rst) state <= FREE;
    else     state <= state_nxt;
  end

  // Ownership next state: lock on an accepted word keeps the owner; an idle unlocked owner releases
  always_comb begin
    state_nxt = state;
    if (accept) begin
      if (cand_lock) state_nxt = (cand_id == REQ_D) ? OWN1 : OWN0;
      else           state_nxt = FREE;
    end else if (!mem_stall) begin
      if (state == OWN0 && !any0 && !req0.lock) state_nxt = FREE;
      if (state == OWN1 && !any1 && !req1.lock) state_nxt = FREE;
    end
  end

  // Drive memory and acks; a rd+wr request goes out as a read
  always_comb begin
    mem_rd      = cand_rd & ~rst;
    mem_wr      = cand_wr & ~cand_rd & ~rst;
    mem_addr    = rst ? '0 : cand_addr;
    mem_data_in = rst ? '0 : cand_data;
    req0.ack    = accept & (cand_id == REQ_I);
    req1.ack    = accept & (cand_id == REQ_D);
  end

  // Flag rd+wr together, or a lock raised without a request while free (that lock is ignored)
  assign err_nxt = (accept & cand_rd & cand_wr) |
                   ((state == FREE) & ((req0.lock & ~any0) | (req1.lock & ~any1)));

  // Register err so it is seen the cycle after the offending request
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else     err <= err_nxt;
  end

  assign tag_in.vld = accept & cand_rd;
  assign tag_in.id  = cand_id;

  mem_arb_rsp_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rsp_pipe (
    .clk          (clk),
    .rst          (rst),
    .tag_in       (tag_in),
    .mem_data_out (mem_data_out),
    .rsp_valid_0  (req0.rsp_valid),
    .rsp_valid_1  (req1.rsp_valid),
    .rsp_data_0   (req0.rsp_data),
    .rsp_data_1   (req1.rsp_data)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run against a transaction-level model.
// Includes a behavioural main memory with fixed read latency.
// Build with or without MEM_ARB_DPRIO_EN; expectations follow the macro.
module tb_mem_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in, mem_data_out;
  logic              mem_rd, mem_wr, mem_stall, err;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) r0 ();
  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) r1 ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0         (r0),
    .req1         (r1),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_stall    (mem_stall),
    .mem_data_out (mem_data_out),
    .err          (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Contents of never-written memory words
  function automatic logic [15:0] init_val(input logic [15:0] a);
    if (a == 16'h0040) return 16'hBEEF;
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // Behavioural main memory: fixed read latency, writes land on the accepting edge
  logic [15:0] mem_arr [logic [15:0]];
  logic [15:0] rd_pipe [RD_LAT];
  assign mem_data_out = rd_pipe[RD_LAT-1];

  always @(posedge clk) begin
    if (mem_rd && !mem_stall)
      rd_pipe[0] <= mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : init_val(mem_addr);
    else
      rd_pipe[0] <= 16'h0000;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_wr && !mem_stall) mem_arr[mem_addr] = mem_data_in;
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    r0.rd = 0; r0.wr = 0; r0.lock = 0; r0.addr = '0; r0.data = '0;
    r1.rd = 0; r1.wr = 0; r1.lock = 0; r1.addr = '0; r1.data = '0;
    mem_stall = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [69:0] obs;
    rst = 1'b1;
    r0.rd = 1; r0.lock = 1; r0.addr = 16'h0011; r0.data = 16'h2222;
    r1.wr = 1; r1.addr = 16'h0033; r1.data = 16'h4444;
    mem_stall = 0;
    for (int k = 0; k < 2; k++) begin
      next_cyc();
      @(negedge clk);
      obs = {r0.ack, r1.ack, mem_rd, mem_wr, mem_addr, mem_data_in, err,
             r0.rsp_valid, r1.rsp_valid, r0.rsp_data, 1'b0, 1'b0, 1'b0};
      n_cmp++;
      if (obs !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs cyc%0d got %h want 0", k, obs);
      end
    end
    idle_inputs();
    next_cyc();
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    r1.rd = 1; r1.addr = 16'h0040;
    @(negedge clk);
    n_cmp++;
    if ({r1.ack, r0.ack, mem_rd, mem_wr, mem_addr} !== {1'b1, 1'b0, 1'b1, 1'b0, 16'h0040}) begin
      n_bad++;
      $display("FAIL single_ack got %b%b%b%b %h want 1010 0040", r1.ack, r0.ack, mem_rd, mem_wr, mem_addr);
    end
    next_cyc();
    r1.rd = 0;
    @(negedge clk);
    n_cmp++;
    if ({r1.rsp_valid, r0.rsp_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL single_early got %b%b want 00", r1.rsp_valid, r0.rsp_valid);
    end
    next_cyc();
    @(negedge clk);
    n_cmp++;
    if ({r1.rsp_valid, r1.rsp_data, r0.rsp_valid, r0.rsp_data} !== {1'b1, 16'hBEEF, 1'b0, 16'h0000}) begin
      n_bad++;
      $display("FAIL single_rsp got v1=%b d1=%h v0=%b d0=%h want 1 beef 0 0000",
               r1.rsp_valid, r1.rsp_data, r0.rsp_valid, r0.rsp_data);
    end
    next_cyc();
    @(negedge clk);
    n_cmp++;
    if ({r1.rsp_valid, r1.rsp_data} !== 17'h0) begin
      n_bad++;
      $display("FAIL single_after got v1=%b d1=%h want 0 0000", r1.rsp_valid, r1.rsp_data);
    end
  endtask

  task automatic test_contention();
    logic [1:0] want;
    do_reset();
    r0.rd = 1; r0.addr = 16'h0010;
    r1.rd = 1; r1.addr = 16'h0020;
    for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_DPRIO_EN
      want = 2'b01;
`else
      want = (k % 2 == 0) ? 2'b10 : 2'b01;
`endif
      @(negedge clk);
      n_cmp++;
      if ({r0.ack, r1.ack} !== want) begin
        n_bad++;
        $display("FAIL contention cyc%0d acks got %b want %b", k, {r0.ack, r1.ack}, want);
      end
      next_cyc();
    end
    idle_inputs();
  endtask

  task automatic test_locked_fill();
    logic [35:0] want;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      r1.rd   = (k < 4);
      r1.lock = (k < 3);
      r1.addr = 16'h0100 + 16'(2 * k);
      r0.rd   = (k >= 1 && k <= 4);
      r0.addr = 16'h0010;
      want = {(k == 4), (k < 4),
              (k >= 2 && k < 6), ((k >= 2 && k < 6) ? init_val(16'h0100 + 16'(2 * (k - 2))) : 16'h0000),
              (k == 6), ((k == 6) ? init_val(16'h0010) : 16'h0000)};
      @(negedge clk);
      n_cmp++;
      if ({r0.ack, r1.ack, r1.rsp_valid, r1.rsp_data, r0.rsp_valid, r0.rsp_data} !== want) begin
        n_bad++;
        $display("FAIL locked_fill cyc%0d got %h want %h", k,
                 {r0.ack, r1.ack, r1.rsp_valid, r1.rsp_data, r0.rsp_valid, r0.rsp_data}, want);
      end
      next_cyc();
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    do_reset();
    r0.wr = 1; r0.addr = 16'h0020; r0.data = 16'h1234;
    for (int k = 0; k < 4; k++) begin
      mem_stall = (k < 3);
      @(negedge clk);
      n_cmp++;
      if ({mem_wr, mem_rd, mem_addr, mem_data_in, r0.ack} !== {1'b1, 1'b0, 16'h0020, 16'h1234, (k == 3)}) begin
        n_bad++;
        $display("FAIL stall_hold cyc%0d got wr=%b rd=%b a=%h d=%h ack=%b want 1 0 0020 1234 %0d",
                 k, mem_wr, mem_rd, mem_addr, mem_data_in, r0.ack, (k == 3));
      end
      next_cyc();
    end
    idle_inputs();
    n_cmp++;
    if (!mem_arr.exists(16'h0020) || mem_arr[16'h0020] !== 16'h1234) begin
      n_bad++;
      $display("FAIL stall_write memory word 0020 not written with 1234");
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    r0.rd = 1; r0.lock = 1; r0.addr = 16'h0040;
    @(negedge clk);
    n_cmp++;
    if (r0.ack !== 1'b1) begin
      n_bad++;
      $display("FAIL midflight_ack got %b want 1", r0.ack);
    end
    next_cyc();
    idle_inputs();
    rst = 1'b1;
    r1.rd = 1; r1.addr = 16'h0030;
    @(negedge clk);
    n_cmp++;
    if ({r0.ack, r1.ack, mem_rd, mem_wr, mem_addr, mem_data_in, err, r0.rsp_valid, r1.rsp_valid} !== '0) begin
      n_bad++;
      $display("FAIL midflight_in_reset got %b%b%b%b %h %h %b%b%b want all 0", r0.ack, r1.ack, mem_rd,
               mem_wr, mem_addr, mem_data_in, err, r0.rsp_valid, r1.rsp_valid);
    end
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({r0.rsp_valid, r0.rsp_data, r1.rsp_valid, r1.ack} !== {1'b0, 16'h0000, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL midflight_drop got v0=%b d0=%h v1=%b ack1=%b want 0 0000 0 1",
               r0.rsp_valid, r0.rsp_data, r1.rsp_valid, r1.ack);
    end
    next_cyc();
    r1.rd = 0;
    @(negedge clk);
    n_cmp++;
    if ({r0.rsp_valid, r1.rsp_valid, err} !== 3'b000) begin
      n_bad++;
      $display("FAIL midflight_quiet got %b%b%b want 000", r0.rsp_valid, r1.rsp_valid, err);
    end
    next_cyc();
  endtask

  task automatic test_proto_err();
    do_reset();
    r0.rd = 1; r0.wr = 1; r0.addr = 16'h0040; r0.data = 16'h7777;
    @(negedge clk);
    n_cmp++;
    if ({r0.ack, mem_rd, mem_wr, err} !== 4'b1100) begin
      n_bad++;
      $display("FAIL proto_issue got ack=%b rd=%b wr=%b err=%b want 1100", r0.ack, mem_rd, mem_wr, err);
    end
    next_cyc();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL proto_err_set got %b want 1", err);
    end
    next_cyc();
    @(negedge clk);
    n_cmp++;
    if ({err, r0.rsp_valid, r0.rsp_data} !== {1'b0, 1'b1, 16'hBEEF}) begin
      n_bad++;
      $display("FAIL proto_err_clear got err=%b v0=%b d0=%h want 0 1 beef", err, r0.rsp_valid, r0.rsp_data);
    end
    next_cyc();
    r1.lock = 1;
    @(negedge clk);
    next_cyc();
    r1.lock = 0;
    r0.rd = 1; r0.addr = 16'h0050;
    @(negedge clk);
    n_cmp++;
    if ({err, r0.ack} !== 2'b11) begin
      n_bad++;
      $display("FAIL lock_noreq got err=%b ack0=%b want 11", err, r0.ack);
    end
    next_cyc();
    r0.rd = 0;
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL lock_noreq_once got %b want 0", err);
    end
    next_cyc();
  endtask

  typedef struct {
    int          due;
    int          id;
    logic [15:0] data;
  } exp_rsp_t;

  task automatic test_random();
    exp_rsp_t    rsp_q[$];
    exp_rsp_t    e;
    logic [15:0] ref_mem [logic [15:0]];
    logic        p_act[2], p_rd[2], p_wr[2], p_lock[2];
    logic [15:0] p_addr[2], p_data[2];
    int          own, rr, cand, r;
    logic        stall, exp_err, exp_rv0, exp_rv1;
    logic [15:0] exp_rd0, exp_rd1;
    logic [70:0] obs, expv;

    do_reset();
    own = -1; rr = 1; exp_err = 0;
    for (int i = 0; i < 2; i++) p_act[i] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!p_act[i] && (own == i || $urandom_range(0, 2) != 0)) begin
          r = $urandom_range(0, 7);
          p_act[i]  = 1;
          p_rd[i]   = (r <= 3) || (r == 7);
          p_wr[i]   = (r >= 4);
          p_lock[i] = ($urandom_range(0, 3) == 0);
          p_addr[i] = 16'h0200 | 16'($urandom_range(0, 255));
          p_data[i] = 16'($urandom);
        end
      end
      stall = ($urandom_range(0, 4) == 0);
      r0.rd = p_act[0] & p_rd[0]; r0.wr = p_act[0] & p_wr[0]; r0.lock = p_act[0] & p_lock[0];
      r0.addr = p_addr[0]; r0.data = p_data[0];
      r1.rd = p_act[1] & p_rd[1]; r1.wr = p_act[1] & p_wr[1]; r1.lock = p_act[1] & p_lock[1];
      r1.addr = p_addr[1]; r1.data = p_data[1];
      mem_stall = stall;

      cand = -1;
      if (own == -1) begin
`ifdef MEM_ARB_DPRIO_EN
        if (p_act[0] && p_act[1]) cand = 1;
`else
        if (p_act[0] && p_act[1]) cand = (rr == 0) ? 1 : 0;
`endif
        else if (p_act[0]) cand = 0;
        else if (p_act[1]) cand = 1;
      end else if (p_act[own]) begin
        cand = own;
      end

      exp_rv0 = 0; exp_rv1 = 0; exp_rd0 = 0; exp_rd1 = 0;
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
        e = rsp_q.pop_front();
        if (e.id == 0) begin exp_rv0 = 1; exp_rd0 = e.data; end
        else begin exp_rv1 = 1; exp_rd1 = e.data; end
      end
      if (cand >= 0)
        expv = {(cand == 0 && !stall), (cand == 1 && !stall), p_rd[cand], p_wr[cand] & ~p_rd[cand],
                p_addr[cand], p_data[cand], exp_err, exp_rv0, exp_rd0, exp_rv1, exp_rd1};
      else
        expv = {4'b0000, 16'h0000, 16'h0000, exp_err, exp_rv0, exp_rd0, exp_rv1, exp_rd1};

      @(negedge clk);
      obs = {r0.ack, r1.ack, mem_rd, mem_wr, mem_addr, mem_data_in, err,
             r0.rsp_valid, r0.rsp_data, r1.rsp_valid, r1.rsp_data};
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL random cyc%0d got %h want %h", cyc, obs, expv);
      end

      exp_err = 0;
      if (cand >= 0 && !stall) begin
        if (p_rd[cand]) begin
          e.due  = cyc + RD_LAT;
          e.id   = cand;
          e.data = ref_mem.exists(p_addr[cand]) ? ref_mem[p_addr[cand]] : init_val(p_addr[cand]);
          rsp_q.push_back(e);
        end else begin
          ref_mem[p_addr[cand]] = p_data[cand];
        end
        exp_err = p_rd[cand] & p_wr[cand];
        if (p_lock[cand]) own = cand;
        else begin
          own = -1;
          rr  = cand;
        end
        p_act[cand] = 0;
      end
      next_cyc();
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_locked_fill();
    test_stall();
    test_reset_midflight();
    test_proto_err();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
